// File: rtl/frame_buffer_ctrl_if.sv
// -----------------------------------------------------------------------------
// frame_buffer_ctrl_if
// Bus bundle between the ping-pong frame buffer controller and its neighbours
// (pixel writer, the two frame buffers and the frame multiplexer).
//
//   WrValid      writer -> ctrl   writer presents a pixel
//   WrReady      ctrl -> writer   controller can accept a pixel
//   Buf0We       ctrl -> Buf0     write strobe for buffer 0
//   Buf1We       ctrl -> Buf1     write strobe for buffer 1
//   WrAddr[AW]   ctrl -> buffers  write address into the back buffer
//   RdAddr[AW]   ctrl -> buffers  read address into the front buffer
//   SelBuf0      ctrl -> mux      display buffer 0
//   SelBlank     ctrl -> mux      display blank
//   SelBuf1      ctrl -> mux      display buffer 1
//   FrameStart   ctrl -> system   first visible cycle of a frame
//   FrameRepeat  ctrl -> system   swap point passed without a new frame
//
// master: the writer/display side; slave: the controller.
// -----------------------------------------------------------------------------
interface frame_buffer_ctrl_if #(
  parameter int AW = 6
);
  logic          WrValid;
  logic          WrReady;
  logic          Buf0We;
  logic          Buf1We;
  logic [AW-1:0] WrAddr;
  logic [AW-1:0] RdAddr;
  logic          SelBuf0;
  logic          SelBlank;
  logic          SelBuf1;
  logic          FrameStart;
  logic          FrameRepeat;

  modport master (
    output WrValid,
    input  WrReady, Buf0We, Buf1We, WrAddr, RdAddr,
    input  SelBuf0, SelBlank, SelBuf1, FrameStart, FrameRepeat
  );

  modport slave (
    input  WrValid,
    output WrReady, Buf0We, Buf1We, WrAddr, RdAddr,
    output SelBuf0, SelBlank, SelBuf1, FrameStart, FrameRepeat
  );
endinterface

// File: rtl/frame_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// frame_buffer_ctrl
// Ping-pong double-buffer controller. Pixel writes are steered into the back
// buffer while a read address walks the front buffer. Buffers swap only on the
// last cycle of the blanking interval, so a displayed frame is never torn.
// Frame period is always BLANK_CYCLES + PIX_PER_FRAME clocks.
//
// Ports:
//   Clk    rising-edge clock
//   Rst_n  asynchronous active-low reset (discards any partial frame)
//   bus    frame_buffer_ctrl_if.slave (write handshake, buffer strobes and
//          addresses, one-hot display selects, frame pulses)
// -----------------------------------------------------------------------------
module frame_buffer_ctrl #(
  parameter int PIX_PER_FRAME = 64,
  parameter int BLANK_CYCLES  = 8,
  parameter int AW            = 6
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  frame_buffer_ctrl_if.slave   bus
);

  localparam int            BW         = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
  localparam logic [AW-1:0] PIX_LAST   = AW'(PIX_PER_FRAME - 1);

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

  state_t        state, nxtState;
  logic [BW-1:0] blankCnt, nxtBlankCnt;
  logic [AW-1:0] pixCnt, nxtPixCnt;
  logic [AW-1:0] wrAddr, nxtWrAddr;
  logic          front, nxtFront;
  logic          frontValid, nxtFrontValid;
  logic          backFull, nxtBackFull;

  // Registered outputs and their next values
  logic [AW-1:0] rdAddr, nxtRdAddr;
  logic          wrReady, nxtWrReady;
  logic          selBuf0, nxtSelBuf0;
  logic          selBlank, nxtSelBlank;
  logic          selBuf1, nxtSelBuf1;
  logic          frameStart, nxtFrameStart;
  logic          frameRepeat, nxtFrameRepeat;

  logic          back;
  logic          wrXfer;
  logic          showing;

  assign back   = ~front;
  assign wrXfer = bus.WrValid && wrReady;

  assign bus.Buf0We      = wrXfer && !back;
  assign bus.Buf1We      = wrXfer && back;
  assign bus.WrReady     = wrReady;
  assign bus.WrAddr      = wrAddr;
  assign bus.RdAddr      = rdAddr;
  assign bus.SelBuf0     = selBuf0;
  assign bus.SelBlank    = selBlank;
  assign bus.SelBuf1     = selBuf1;
  assign bus.FrameStart  = frameStart;
  assign bus.FrameRepeat = frameRepeat;

  // State register: all control state plus the registered outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= BLANK;
      blankCnt    <= '0;
      pixCnt      <= '0;
      wrAddr      <= '0;
      front       <= 1'b0;
      frontValid  <= 1'b0;
      backFull    <= 1'b0;
      rdAddr      <= '0;
      wrReady     <= 1'b1;
      selBuf0     <= 1'b0;
      selBlank    <= 1'b1;
      selBuf1     <= 1'b0;
      frameStart  <= 1'b0;
      frameRepeat <= 1'b0;
    end else begin
      state       <= nxtState;
      blankCnt    <= nxtBlankCnt;
      pixCnt      <= nxtPixCnt;
      wrAddr      <= nxtWrAddr;
      front       <= nxtFront;
      frontValid  <= nxtFrontValid;
      backFull    <= nxtBackFull;
      rdAddr      <= nxtRdAddr;
      wrReady     <= nxtWrReady;
      selBuf0     <= nxtSelBuf0;
      selBlank    <= nxtSelBlank;
      selBuf1     <= nxtSelBuf1;
      frameStart  <= nxtFrameStart;
      frameRepeat <= nxtFrameRepeat;
    end
  end

  // Next-state logic: display timing, swap decision and write address
  always_comb begin
    nxtState      = state;
    nxtBlankCnt   = blankCnt;
    nxtPixCnt     = pixCnt;
    nxtFront      = front;
    nxtFrontValid = frontValid;
    nxtBackFull   = backFull;
    nxtWrAddr     = wrAddr;

    case (state)
      BLANK: begin
        if (blankCnt == BLANK_LAST) begin
          nxtState    = SHOW;
          nxtBlankCnt = '0;
          nxtPixCnt   = '0;
          // Swap uses the BackFull seen at the start of this cycle; a final
          // write landing now only becomes visible at the next swap point.
          if (backFull) begin
            nxtFront      = ~front;
            nxtFrontValid = 1'b1;
            nxtBackFull   = 1'b0;
          end
        end else begin
          nxtBlankCnt = blankCnt + BW'(1);
        end
      end
      SHOW: begin
        if (pixCnt == PIX_LAST) begin
          nxtState    = BLANK;
          nxtBlankCnt = '0;
          nxtPixCnt   = '0;
        end else begin
          nxtPixCnt = pixCnt + AW'(1);
        end
      end
    endcase

    // A transfer is only possible while BackFull is clear, so it never
    // collides with the swap clearing BackFull above.
    if (wrXfer) begin
      if (wrAddr == PIX_LAST) begin
        nxtWrAddr   = '0;
        nxtBackFull = 1'b1;
      end else begin
        nxtWrAddr = wrAddr + AW'(1);
      end
    end
  end

  // Output logic: outputs are decoded from next-state values and registered,
  // so in every cycle they line up with the state actually held in that cycle.
  always_comb begin
    showing        = (nxtState == SHOW) && nxtFrontValid;
    nxtSelBuf0     = showing && !nxtFront;
    nxtSelBuf1     = showing && nxtFront;
    nxtSelBlank    = !showing;
    nxtRdAddr      = (nxtState == SHOW) ? nxtPixCnt : '0;
    nxtFrameStart  = (nxtState == SHOW) && (nxtPixCnt == '0);
    nxtFrameRepeat = (nxtState == BLANK) && (nxtBlankCnt == BLANK_LAST) &&
                     !nxtBackFull && nxtFrontValid;
    nxtWrReady     = !nxtBackFull;
  end

endmodule
